// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the PPU hazard/forwarding controller: forwarding-mux
// select encodings, FSM state encodings and the packed pipeline-control word.
package pipeline_hazard_ctrl_pkg;

   // Forwarding-mux select encodings (one 2-bit select per ID source lane)
   localparam logic [1:0] FWD_EX  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;
   localparam logic [1:0] FWD_RF  = 2'b11;

   // Controller FSM states
   typedef enum logic [1:0] {
      S_RUN      = 2'b00,
      S_LU_STALL = 2'b01,
      S_MEM_WAIT = 2'b10
   } hz_state_t;

   // Pipeline control outputs gathered into one word
   typedef struct packed {
      logic pc_ld;
      logic if_id_ld;
      logic id_ex_nop;
      logic if_id_flush;
      logic pipe_hold;
   } pipe_ctrl_t;

   // Builds a control word from its individual fields
   function automatic pipe_ctrl_t make_ctrl(input logic pc_ld, input logic if_id_ld,
                                            input logic id_ex_nop, input logic if_id_flush,
                                            input logic pipe_hold);
      pipe_ctrl_t w;
      w.pc_ld       = pc_ld;
      w.if_id_ld    = if_id_ld;
      w.id_ex_nop   = id_ex_nop;
      w.if_id_flush = if_id_flush;
      w.pipe_hold   = pipe_hold;
      return w;
   endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle of ID-stage operand, downstream-stage destination and pipeline
// control signals exchanged between the PPU datapath and the hazard controller.
// The master modport is the datapath side, the slave modport the controller.
interface pipeline_hazard_ctrl_if #(
   parameter int NUM_SRC = 3,
   parameter int REG_W   = 4
);
   logic [NUM_SRC*REG_W-1:0] id_src;
   logic [NUM_SRC-1:0]       id_src_vld;
   logic [REG_W-1:0]         ex_rd;
   logic                     ex_rf_en;
   logic                     ex_load;
   logic [REG_W-1:0]         mem_rd;
   logic                     mem_rf_en;
   logic [REG_W-1:0]         wb_rd;
   logic                     wb_rf_en;
   logic                     mem_busy;
   logic                     branch_tkn;
   logic [NUM_SRC*2-1:0]     fwd_sel;
   logic                     pc_ld;
   logic                     if_id_ld;
   logic                     id_ex_nop;
   logic                     if_id_flush;
   logic                     pipe_hold;
   logic [15:0]              stall_cnt;

   modport master (
      output id_src, id_src_vld, ex_rd, ex_rf_en, ex_load, mem_rd, mem_rf_en,
             wb_rd, wb_rf_en, mem_busy, branch_tkn,
      input  fwd_sel, pc_ld, if_id_ld, id_ex_nop, if_id_flush, pipe_hold, stall_cnt
   );

   modport slave (
      input  id_src, id_src_vld, ex_rd, ex_rf_en, ex_load, mem_rd, mem_rf_en,
             wb_rd, wb_rf_en, mem_busy, branch_tkn,
      output fwd_sel, pc_ld, if_id_ld, id_ex_nop, if_id_flush, pipe_hold, stall_cnt
   );
endinterface

// File: rtl/pipeline_hazard_ctrl_fwd_select_lane.sv
// Forwarding comparator for a single ID source operand. Picks the youngest
// in-flight producer of the operand: EX, then MEM, then WB, else the RF.
// A load in EX has no data yet, so it never selects the EX path. The PC
// specifier and unused lanes always read the register file.
module fwd_select_lane
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter int REG_W  = 4,
   parameter int PC_REG = 15
) (
   input  logic [REG_W-1:0] src,
   input  logic             vld,
   input  logic [REG_W-1:0] ex_rd,
   input  logic             ex_rf_en,
   input  logic             ex_load,
   input  logic [REG_W-1:0] mem_rd,
   input  logic             mem_rf_en,
   input  logic [REG_W-1:0] wb_rd,
   input  logic             wb_rf_en,
   output logic [1:0]       sel
);
   localparam logic [REG_W-1:0] PC_SPEC = REG_W'(PC_REG);

   // Priority select of the forwarding source for this lane
   always_comb begin
      sel = FWD_RF;
      if (!vld || (src == PC_SPEC)) begin
         sel = FWD_RF;
      end else if (ex_rf_en && !ex_load && (src == ex_rd)) begin
         sel = FWD_EX;
      end else if (mem_rf_en && (src == mem_rd)) begin
         sel = FWD_MEM;
      end else if (wb_rf_en && (src == wb_rd)) begin
         sel = FWD_WB;
      end else begin
         sel = FWD_RF;
      end
   end
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/forwarding controller for the pipelined ARM-subset PPU, placed beside
// the ID stage. Generates per-lane forwarding selects, load-use bubbles, a
// pipe freeze while data RAM is busy and an IF/ID flush on a taken branch.
// Optional feature macro: HAZARD_PERF_CNT_EN enables the stall-cycle counter;
// without it stall_cnt is constant zero.
//
// Load-use: the cycle the hazard is detected is the first bubble. lu_cnt holds
// the number of further LU_STALL cycles still owed, so LU_CYCLES==1 never
// enters LU_STALL. A RAM wait arriving during LU_STALL freezes lu_cnt and the
// stall resumes where it left off. In RUN, a busy RAM freezes the pipe in the
// same cycle it is seen; in LU_STALL the busy cycle still issues its bubble.
module pipeline_hazard_ctrl
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter int NUM_SRC   = 3,
   parameter int REG_W     = 4,
   parameter int LU_CYCLES = 1,
   parameter int PC_REG    = 15
) (
   input logic                   clk,
   input logic                   Reset,
   pipeline_hazard_ctrl_if.slave hz
);
   localparam logic [REG_W-1:0] PC_SPEC  = REG_W'(PC_REG);
   localparam logic [3:0]       LU_EXTRA = 4'(LU_CYCLES - 1);

   logic [NUM_SRC*2-1:0] lane_sel_s;
   logic                 lu_hit_s;
   pipe_ctrl_t           ctrl_s;
   hz_state_t            state_r;
   logic [3:0]           lu_cnt_r;
   logic                 ret_lu_r;

   for (genvar g = 0; g < NUM_SRC; g++) begin : g_lane
      fwd_select_lane #(
         .REG_W  (REG_W),
         .PC_REG (PC_REG)
      ) u_lane (
         .src       (hz.id_src[g*REG_W +: REG_W]),
         .vld       (hz.id_src_vld[g]),
         .ex_rd     (hz.ex_rd),
         .ex_rf_en  (hz.ex_rf_en),
         .ex_load   (hz.ex_load),
         .mem_rd    (hz.mem_rd),
         .mem_rf_en (hz.mem_rf_en),
         .wb_rd     (hz.wb_rd),
         .wb_rf_en  (hz.wb_rf_en),
         .sel       (lane_sel_s[g*2 +: 2])
      );
   end

   // Load-use detection: a valid non-PC operand needs the result of the load in EX
   always_comb begin
      lu_hit_s = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         lu_hit_s = lu_hit_s | (hz.id_src_vld[i] &&
                                (hz.id_src[i*REG_W +: REG_W] == hz.ex_rd) &&
                                (hz.id_src[i*REG_W +: REG_W] != PC_SPEC));
      end
      lu_hit_s = lu_hit_s & hz.ex_load & hz.ex_rf_en;
   end

   // Stall/wait FSM with bubble counter and return-to-stall flag
   always_ff @(posedge clk) begin
      if (Reset) begin
         state_r  <= S_RUN;
         lu_cnt_r <= 4'd0;
         ret_lu_r <= 1'b0;
      end else begin
         case (state_r)
            S_RUN: begin
               if (hz.mem_busy) begin
                  state_r  <= S_MEM_WAIT;
                  ret_lu_r <= 1'b0;
               end else if (hz.branch_tkn) begin
                  state_r <= S_RUN;
               end else if (lu_hit_s) begin
                  lu_cnt_r <= LU_EXTRA;
                  state_r  <= (LU_EXTRA == 4'd0) ? S_RUN : S_LU_STALL;
               end else begin
                  state_r <= S_RUN;
               end
            end
            S_LU_STALL: begin
               if (hz.mem_busy) begin
                  state_r  <= S_MEM_WAIT;
                  ret_lu_r <= 1'b1;
               end else if (lu_cnt_r <= 4'd1) begin
                  state_r  <= S_RUN;
                  lu_cnt_r <= 4'd0;
               end else begin
                  lu_cnt_r <= lu_cnt_r - 4'd1;
               end
            end
            S_MEM_WAIT: begin
               if (!hz.mem_busy) begin
                  state_r  <= ret_lu_r ? S_LU_STALL : S_RUN;
                  ret_lu_r <= 1'b0;
               end else begin
                  state_r <= S_MEM_WAIT;
               end
            end
            default: begin
               state_r  <= S_RUN;
               lu_cnt_r <= 4'd0;
               ret_lu_r <= 1'b0;
            end
         endcase
      end
   end

   // Pipeline control decode from state and the current cycle's hazards
   always_comb begin
      ctrl_s = make_ctrl(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      if (Reset) begin
         ctrl_s = make_ctrl(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      end else begin
         case (state_r)
            S_RUN: begin
               if (hz.mem_busy) begin
                  ctrl_s = make_ctrl(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
               end else if (hz.branch_tkn) begin
                  ctrl_s = make_ctrl(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
               end else if (lu_hit_s) begin
                  ctrl_s = make_ctrl(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
               end else begin
                  ctrl_s = make_ctrl(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
               end
            end
            S_LU_STALL: ctrl_s = make_ctrl(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            S_MEM_WAIT: ctrl_s = make_ctrl(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            default:    ctrl_s = make_ctrl(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
         endcase
      end
   end

   // Drive interface outputs; reset forces every operand to the register file
   always_comb begin
      hz.pc_ld       = ctrl_s.pc_ld;
      hz.if_id_ld    = ctrl_s.if_id_ld;
      hz.id_ex_nop   = ctrl_s.id_ex_nop;
      hz.if_id_flush = ctrl_s.if_id_flush;
      hz.pipe_hold   = ctrl_s.pipe_hold;
      if (Reset) begin
         hz.fwd_sel = {NUM_SRC{FWD_RF}};
      end else begin
         hz.fwd_sel = lane_sel_s;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [15:0] stall_cnt_r;

   // Saturating count of cycles in which the PC did not advance
   always_ff @(posedge clk) begin
      if (Reset) begin
         stall_cnt_r <= 16'd0;
      end else if (!ctrl_s.pc_ld && (stall_cnt_r != 16'hFFFF)) begin
         stall_cnt_r <= stall_cnt_r + 16'd1;
      end else begin
         stall_cnt_r <= stall_cnt_r;
      end
   end

   assign hz.stall_cnt = stall_cnt_r;
`else
   assign hz.stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios followed by
// randomized traffic, all compared against a cycle-level reference model that
// tracks outstanding bubbles and a RAM-wait flag.
module tb_pipeline_hazard_ctrl;
   localparam int NS  = 3;
   localparam int RW  = 4;
   localparam int LU  = 2;
   localparam int PCR = 15;

   logic clk = 1'b0;
   logic Reset;
   int   checks = 0;
   int   failures = 0;

   // reference model state: bubbles still owed, waiting on RAM, stall counter
   int   m_lu_left, n_lu_left;
   bit   m_wait, n_wait;
   int   m_cnt, n_cnt;
   logic [4:0]    e_ctrl;
   logic [NS*2-1:0] e_fwd;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl_if #(.NUM_SRC(NS), .REG_W(RW)) hz();

   pipeline_hazard_ctrl #(
      .NUM_SRC(NS), .REG_W(RW), .LU_CYCLES(LU), .PC_REG(PCR)
   ) dut (
      .clk   (clk),
      .Reset (Reset),
      .hz    (hz)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [1:0] ref_fwd(input int src, input bit vld);
      if (!vld || src == PCR) return 2'b11;
      if (hz.ex_rf_en && !hz.ex_load && src == int'(hz.ex_rd)) return 2'b00;
      if (hz.mem_rf_en && src == int'(hz.mem_rd)) return 2'b10;
      if (hz.wb_rf_en && src == int'(hz.wb_rd)) return 2'b01;
      return 2'b11;
   endfunction

   task automatic idle();
      hz.id_src = '0; hz.id_src_vld = '0;
      hz.ex_rd = '0; hz.ex_rf_en = 1'b0; hz.ex_load = 1'b0;
      hz.mem_rd = '0; hz.mem_rf_en = 1'b0;
      hz.wb_rd = '0; hz.wb_rf_en = 1'b0;
      hz.mem_busy = 1'b0; hz.branch_tkn = 1'b0;
      Reset = 1'b0;
   endtask

   task automatic set_lane(input int i, input int src, input bit vld);
      hz.id_src[i*RW +: RW] = RW'(src);
      hz.id_src_vld[i] = vld;
   endtask

   // at the falling edge: compute expected outputs and next model state, compare
   task automatic settle();
      bit hazard;
      int src;
      @(negedge clk);
      hazard = 1'b0;
      for (int i = 0; i < NS; i++) begin
         src = int'(hz.id_src[i*RW +: RW]);
         if (hz.id_src_vld[i] && src == int'(hz.ex_rd) && src != PCR) hazard = 1'b1;
         e_fwd[i*2 +: 2] = ref_fwd(src, hz.id_src_vld[i]);
      end
      hazard = hazard && hz.ex_load && hz.ex_rf_en;
      n_lu_left = m_lu_left; n_wait = m_wait; n_cnt = m_cnt;
      // e_ctrl = {pc_ld, if_id_ld, id_ex_nop, if_id_flush, pipe_hold}
      if (Reset) begin
         e_ctrl = 5'b11100; e_fwd = '1;
         n_lu_left = 0; n_wait = 1'b0; n_cnt = 0;
      end else if (m_wait) begin
         e_ctrl = 5'b00001;
         if (!hz.mem_busy) n_wait = 1'b0;
      end else if (m_lu_left > 0) begin
         e_ctrl = 5'b00100;
         if (hz.mem_busy) n_wait = 1'b1;
         else n_lu_left = m_lu_left - 1;
      end else if (hz.mem_busy) begin
         e_ctrl = 5'b00001; n_wait = 1'b1;
      end else if (hz.branch_tkn) begin
         e_ctrl = 5'b11010;
      end else if (hazard) begin
         e_ctrl = 5'b00100; n_lu_left = LU - 1;
      end else begin
         e_ctrl = 5'b11000;
      end
      if (!Reset && !e_ctrl[4] && m_cnt < 65535) n_cnt = m_cnt + 1;
      chk("ctrl", {hz.pc_ld, hz.if_id_ld, hz.id_ex_nop, hz.if_id_flush, hz.pipe_hold}, e_ctrl);
      chk("fwd_sel", hz.fwd_sel, e_fwd);
`ifdef HAZARD_PERF_CNT_EN
      chk("stall_cnt", hz.stall_cnt, m_cnt);
`else
      chk("stall_cnt", hz.stall_cnt, 32'd0);
`endif
   endtask

   task automatic advance();
      @(posedge clk);
      m_lu_left = n_lu_left; m_wait = n_wait; m_cnt = n_cnt;
      #1;
   endtask

   function automatic int rand_reg();
      return ($urandom_range(0, 7) == 0) ? PCR : int'($urandom_range(0, 7));
   endfunction

   initial begin
      idle();
      Reset = 1'b1;
      m_lu_left = 0; m_wait = 1'b0; m_cnt = 0;
      @(posedge clk); #1;
      settle(); chk("rst_pc_ld", hz.pc_ld, 1'b1); chk("rst_nop", hz.id_ex_nop, 1'b1); advance();
      idle();

      // forwarding from EX
      hz.ex_rd = 4'd3; hz.ex_rf_en = 1'b1; set_lane(0, 3, 1'b1);
      settle(); chk("t1_fwd0", hz.fwd_sel[1:0], 2'b00); chk("t1_pc_ld", hz.pc_ld, 1'b1); advance();

      // EX > MEM > WB priority
      idle();
      hz.ex_rd = 4'd5; hz.mem_rd = 4'd5; hz.wb_rd = 4'd5;
      hz.ex_rf_en = 1'b1; hz.mem_rf_en = 1'b1; hz.wb_rf_en = 1'b1; set_lane(1, 5, 1'b1);
      settle(); chk("t2_ex", hz.fwd_sel[3:2], 2'b00); advance();
      hz.ex_rf_en = 1'b0;
      settle(); chk("t2_mem", hz.fwd_sel[3:2], 2'b10); advance();
      hz.mem_rf_en = 1'b0;
      settle(); chk("t2_wb", hz.fwd_sel[3:2], 2'b01); advance();

      // load-use, two bubbles then MEM forwarding
      idle();
      hz.ex_load = 1'b1; hz.ex_rf_en = 1'b1; hz.ex_rd = 4'd2; set_lane(0, 2, 1'b1);
      settle(); chk("t3_b1_pc", hz.pc_ld, 1'b0); chk("t3_b1_nop", hz.id_ex_nop, 1'b1); advance();
      idle();
      settle(); chk("t3_b2_pc", hz.pc_ld, 1'b0); chk("t3_b2_nop", hz.id_ex_nop, 1'b1); advance();
      hz.mem_rd = 4'd2; hz.mem_rf_en = 1'b1; set_lane(0, 2, 1'b1);
      settle(); chk("t3_run_pc", hz.pc_ld, 1'b1); chk("t3_fwd", hz.fwd_sel[1:0], 2'b10); advance();

      // RAM busy for three cycles in the middle of a load-use stall
      idle();
      hz.ex_load = 1'b1; hz.ex_rf_en = 1'b1; hz.ex_rd = 4'd4; set_lane(2, 4, 1'b1);
      settle(); advance();
      idle(); hz.mem_busy = 1'b1;
      settle(); chk("t4_stall_nop", hz.id_ex_nop, 1'b1); advance();
      for (int k = 0; k < 3; k++) begin
         hz.mem_busy = (k < 2);
         settle(); chk("t4_hold", hz.pipe_hold, 1'b1); advance();
      end
      hz.mem_busy = 1'b0;
      settle(); chk("t4_resume_nop", hz.id_ex_nop, 1'b1); chk("t4_resume_hold", hz.pipe_hold, 1'b0); advance();
      settle(); chk("t4_run_pc", hz.pc_ld, 1'b1); advance();

      // taken branch flushes in RUN, not while RAM busy
      hz.branch_tkn = 1'b1;
      settle(); chk("t5_flush", hz.if_id_flush, 1'b1); advance();
      hz.mem_busy = 1'b1;
      settle(); chk("t5_busy_flush", hz.if_id_flush, 1'b0); advance();
      settle(); chk("t5_wait_flush", hz.if_id_flush, 1'b0); advance();

      // reset in the middle of a RAM wait; PC specifier never forwarded
      Reset = 1'b1; hz.branch_tkn = 1'b0; hz.wb_rd = 4'd15; hz.wb_rf_en = 1'b1; set_lane(0, 15, 1'b1);
      settle(); chk("t6_rst_fwd", hz.fwd_sel, 6'h3F); chk("t6_rst_pc", hz.pc_ld, 1'b1); advance();
      Reset = 1'b0; hz.mem_busy = 1'b0;
      settle(); chk("t6_run_pc", hz.pc_ld, 1'b1); chk("t6_cnt", hz.stall_cnt, 16'd0);
      chk("t6_pc_fwd", hz.fwd_sel[1:0], 2'b11); advance();

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         Reset = ($urandom_range(0, 149) == 0);
         for (int i = 0; i < NS; i++) set_lane(i, rand_reg(), ($urandom_range(0, 3) != 0));
         hz.ex_rd = RW'(rand_reg()); hz.mem_rd = RW'(rand_reg()); hz.wb_rd = RW'(rand_reg());
         hz.ex_rf_en = ($urandom_range(0, 3) != 0);
         hz.mem_rf_en = $urandom_range(0, 1);
         hz.wb_rf_en = $urandom_range(0, 1);
         hz.ex_load = ($urandom_range(0, 2) == 0);
         hz.mem_busy = hz.mem_busy ? ($urandom_range(0, 9) < 6) : ($urandom_range(0, 9) == 0);
         hz.branch_tkn = ($urandom_range(0, 7) == 0);
         settle(); advance();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
